capture_ctrl: RTL and testbench

Acquisition sequencer for the scope path. It sits between the decimated 8-bit ADC sample stream and a dual-port frame buffer that the VGA renderer reads. It keeps a circular pre-trigger history, detects a level/slope trigger (or forces one in auto mode), and writes exactly one screen-width frame. It then holds that frame until the renderer acknowledges it has drawn it.

---
 rtl/capture_pkg.sv | 35 +++
 rtl/trig_detect.sv | 54 +++++
 rtl/capture_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_capture_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// capture_pkg: definitions shared by the acquisition sequencer and the renderer.
//   cap_state_t  - sequencer state encoding
//   SLOPE_*      - encodings of the trig_rising input
//   mod_step()   - modular add/subtract over a non power-of-2 buffer length.
//                  The renderer's read pointer uses it too.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        WAIT_TRIG,
        POST,
        DONE
    } cap_state_t;

    localparam logic SLOPE_FALL = 1'b0;
    localparam logic SLOPE_RISE = 1'b1;

    // Returns (a + delta) mod depth, or (a - delta) mod depth when sub=1.
    // Requires a < depth and delta <= depth, so one conditional correction
    // is enough and no divider is inferred.
    function automatic logic [31:0] mod_step(input logic [31:0] a,
                                             input logic [31:0] delta,
                                             input logic [31:0] depth,
                                             input logic        sub);
        logic [31:0] r;
        if (sub) begin
            r = (a >= delta) ? a - delta : a + depth - delta;
        end else begin
            r = (a + delta >= depth) ? a + delta - depth : a + delta;
        end
        return r;
    endfunction

endpackage

// File: rtl/trig_detect.sv
// trig_detect: level/slope crossing detector for the capture sequencer.
//   clk, reset       - clock, asynchronous active-low reset
//   clear            - invalidates the stored previous sample (pulsed on PREFILL entry)
//   sample_valid     - qualifies sample
//   sample           - current sample
//   trig_level       - threshold
//   trig_rising      - SLOPE_RISE / SLOPE_FALL
//   hit              - combinational, high for the one valid sample that completes a crossing
module trig_detect
    import capture_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample,
    input  logic [DW-1:0] trig_level,
    input  logic          trig_rising,
    output logic          hit
);

    logic [DW-1:0] prev_reg;
    logic          prev_valid_reg;

    // clear wins over a sample in the same cycle. The first sample of a new
    // capture therefore never pairs with data from the previous one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_reg       <= '0;
            prev_valid_reg <= 1'b0;
        end else if (clear) begin
            prev_valid_reg <= 1'b0;
        end else if (sample_valid) begin
            prev_reg       <= sample;
            prev_valid_reg <= 1'b1;
        end
    end

    // Compare the registered previous sample with the live one. The decision
    // is made on the crossing sample itself.
    always_comb begin
        hit = 1'b0;
        if (prev_valid_reg && sample_valid) begin
            case (trig_rising)
                SLOPE_RISE: hit = (prev_reg < trig_level) && (sample >= trig_level);
                SLOPE_FALL: hit = (prev_reg > trig_level) && (sample <= trig_level);
                default:    hit = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: scope acquisition sequencer.
// It keeps a circular pre-trigger history in the frame buffer and waits for a
// level/slope trigger, or forces one after a timeout. It then finishes one
// DEPTH-sample frame and holds it until the renderer acknowledges it.
//   clk, reset                   - clock, asynchronous active-low reset
//   sample_valid, sample         - decimated ADC stream
//   trig_level, trig_rising      - trigger threshold and slope
//   auto_mode, auto_timeout      - force a trigger after auto_timeout WAIT_TRIG samples
//   continuous                   - rearm after frame_ack instead of idling
//   arm, abort, frame_ack        - control pulses
//   wr_en, wr_addr, wr_data      - frame buffer write port (registered)
//   frame_ready, start_addr      - frame complete; address of its oldest sample
//   forced, busy                 - last frame was auto-triggered; not idle
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int DW     = 8,
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10,
    parameter int PRE    = 64,
    parameter int TO_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DW-1:0]     sample,
    input  logic [DW-1:0]     trig_level,
    input  logic              trig_rising,
    input  logic              auto_mode,
    input  logic              continuous,
    input  logic [TO_W-1:0]   auto_timeout,
    input  logic              arm,
    input  logic              abort,
    input  logic              frame_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DW-1:0]     wr_data,
    output logic              frame_ready,
    output logic [ADDR_W-1:0] start_addr,
    output logic              forced,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(PRE - 1);
    localparam logic [ADDR_W-1:0] POST_LEN = ADDR_W'(DEPTH - PRE - 1);

    cap_state_t        state_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] cnt_reg;       // PREFILL: samples taken; POST: samples left
    logic [ADDR_W-1:0] trig_addr_reg;
    logic [TO_W-1:0]   to_cnt_reg;

    logic              hit;
    logic              clear_prev;
    logic              wr_now;
    logic              force_now;
    logic [ADDR_W-1:0] ptr_inc;
    logic [ADDR_W-1:0] start_from_trig;
    logic [ADDR_W-1:0] start_from_ptr;

    assign wr_now = sample_valid && !abort &&
                    (state_reg == PREFILL || state_reg == WAIT_TRIG || state_reg == POST);
    assign force_now = auto_mode && (to_cnt_reg >= auto_timeout);

    // Every route into PREFILL (arm from IDLE, continuous rearm) starts a fresh history.
    assign clear_prev = !abort && ((state_reg == IDLE && arm) ||
                                   (state_reg == DONE && frame_ack && continuous));

    assign ptr_inc         = ADDR_W'(mod_step(32'(wr_ptr_reg), 32'd1, DEPTH, 1'b0));
    assign start_from_trig = ADDR_W'(mod_step(32'(trig_addr_reg), PRE, DEPTH, 1'b1));
    assign start_from_ptr  = ADDR_W'(mod_step(32'(wr_ptr_reg), PRE, DEPTH, 1'b1));

    trig_detect #(.DW(DW)) u_trig (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear_prev),
        .sample_valid (sample_valid),
        .sample       (sample),
        .trig_level   (trig_level),
        .trig_rising  (trig_rising),
        .hit          (hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            cnt_reg       <= '0;
            trig_addr_reg <= '0;
            to_cnt_reg    <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            frame_ready   <= 1'b0;
            start_addr    <= '0;
            forced        <= 1'b0;
            busy          <= 1'b0;
        end else begin
            wr_en       <= wr_now;
            frame_ready <= 1'b0;
            if (wr_now) begin
                wr_addr    <= wr_ptr_reg;
                wr_data    <= sample;
                wr_ptr_reg <= ptr_inc;
            end

            if (abort) begin
                state_reg <= IDLE;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (arm) begin
                            state_reg  <= PREFILL;
                            busy       <= 1'b1;
                            wr_ptr_reg <= '0;
                            cnt_reg    <= '0;
                            to_cnt_reg <= '0;
                        end
                    end
                    PREFILL: begin
                        if (sample_valid) begin
                            if (cnt_reg == PRE_LAST) begin
                                state_reg  <= WAIT_TRIG;
                                to_cnt_reg <= '0;
                            end else begin
                                cnt_reg <= cnt_reg + ADDR_W'(1);
                            end
                        end
                    end
                    WAIT_TRIG: begin
                        if (sample_valid) begin
                            if (hit || force_now) begin
                                // A real crossing on the same sample outranks the timeout.
                                trig_addr_reg <= wr_ptr_reg;
                                forced        <= !hit;
                                cnt_reg       <= POST_LEN;
                                if (POST_LEN == '0) begin
                                    state_reg  <= DONE;
                                    start_addr <= start_from_ptr;
                                end else begin
                                    state_reg <= POST;
                                end
                            end else if (to_cnt_reg != '1) begin
                                to_cnt_reg <= to_cnt_reg + TO_W'(1);
                            end
                        end
                    end
                    POST: begin
                        if (sample_valid) begin
                            if (cnt_reg == ADDR_W'(1)) begin
                                state_reg  <= DONE;
                                start_addr <= start_from_trig;
                            end else begin
                                cnt_reg <= cnt_reg - ADDR_W'(1);
                            end
                        end
                    end
                    DONE: begin
                        if (frame_ack) begin
                            if (continuous) begin
                                // Rearm exactly as arm does, so each frame starts at address 0.
                                state_reg  <= PREFILL;
                                wr_ptr_reg <= '0;
                                cnt_reg    <= '0;
                                to_cnt_reg <= '0;
                            end else begin
                                state_reg <= IDLE;
                                busy      <= 1'b0;
                            end
                        end else begin
                            frame_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: self-checking bench for capture_ctrl.
// For each frame the bench first builds the whole valid-sample stream. It
// finds the trigger index by applying the crossing and timeout rules directly
// to that stream. It then derives the expected write sequence
// (write i -> address i mod DEPTH, data stream[i]), the start address and the
// forced flag. Finally it drives the stream with optional gaps and compares.
module tb_capture_ctrl;

    localparam int DW       = 8;
    localparam int DEPTH    = 640;
    localparam int ADDR_W   = 10;
    localparam int PRE      = 64;
    localparam int TO_W     = 16;
    localparam int POST_LEN = DEPTH - PRE - 1;

    localparam int K_UP    = 0;  // ascending ramp from p
    localparam int K_DOWN  = 1;  // descending ramp from p
    localparam int K_CONST = 2;  // constant p
    localparam int K_RAND  = 3;  // uniform random
    localparam int K_STEP  = 4;  // 50 until index p, then 200

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              sample_valid = 1'b0;
    logic [DW-1:0]     sample = '0;
    logic [DW-1:0]     trig_level = '0;
    logic              trig_rising = 1'b0;
    logic              auto_mode = 1'b0;
    logic              continuous = 1'b0;
    logic [TO_W-1:0]   auto_timeout = '0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic              frame_ack = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DW-1:0]     wr_data;
    logic              frame_ready;
    logic [ADDR_W-1:0] start_addr;
    logic              forced;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int stream[$];
    int exp_addr[$];
    int exp_data[$];
    int wr_seen = 0;
    int frame_no = 0;

    always #5 clk = ~clk;

    capture_ctrl #(
        .DW(DW), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PRE(PRE), .TO_W(TO_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .trig_level   (trig_level),
        .trig_rising  (trig_rising),
        .auto_mode    (auto_mode),
        .continuous   (continuous),
        .auto_timeout (auto_timeout),
        .arm          (arm),
        .abort        (abort),
        .frame_ack    (frame_ack),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_ready  (frame_ready),
        .start_addr   (start_addr),
        .forced       (forced),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // One clock. Outputs are observed 1 time unit after the edge. Every
    // write strobe is matched against the next expected write.
    task automatic step();
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
            if (wr_seen < exp_addr.size()) begin
                check("wr_addr", wr_addr, exp_addr[wr_seen]);
                check("wr_data", wr_data, exp_data[wr_seen]);
            end else begin
                check("extra_write", wr_en, 1'b0);
            end
            wr_seen++;
        end
    endtask

    // Build the valid-sample stream and apply the trigger rules to it.
    task automatic build(input int kind, input int p, input int lvl, input bit rising,
                         input bit auto_m, input int tmo, input int max_len,
                         output int trig, output bit frc);
        int v;
        bit real_hit;
        stream.delete();
        trig = -1;
        frc  = 1'b0;
        for (int i = 0; i < max_len; i++) begin
            case (kind)
                K_UP:    v = (p + i) % 256;
                K_DOWN:  v = (((p - i) % 256) + 256) % 256;
                K_CONST: v = p;
                K_RAND:  v = int'($urandom_range(255));
                default: v = (i < p) ? 50 : 200;
            endcase
            stream.push_back(v);
            if (trig < 0 && i >= PRE) begin
                real_hit = rising ? (stream[i-1] < lvl && v >= lvl)
                                  : (stream[i-1] > lvl && v <= lvl);
                if (real_hit || (auto_m && (i - PRE) >= tmo)) begin
                    trig = i;
                    frc  = !real_hit;
                end
            end
            if (trig >= 0 && i == trig + POST_LEN) break;
        end
        exp_addr.delete();
        exp_data.delete();
        foreach (stream[i]) begin
            exp_addr.push_back(i % DEPTH);
            exp_data.push_back(stream[i]);
        end
    endtask

    // stop_at >= 0: drive only that many valid samples and return mid-capture.
    task automatic run_frame(input string name, input int kind, input int p, input int lvl,
                             input bit rising, input bit auto_m, input int tmo, input int duty,
                             input bit cont, input bit do_arm, input int max_len,
                             input int stop_at);
        int trig;
        bit frc;
        int n;
        build(kind, p, lvl, rising, auto_m, tmo, max_len, trig, frc);
        trig_level   = DW'(lvl);
        trig_rising  = rising;
        auto_mode    = auto_m;
        auto_timeout = TO_W'(tmo);
        continuous   = cont;
        wr_seen      = 0;
        frame_no++;
        if (do_arm) begin
            check("idle_busy", busy, 1'b0);
            arm = 1'b1;
            step();
            arm = 1'b0;
            check("arm_busy", busy, 1'b1);
        end
        n = (stop_at >= 0) ? stop_at : stream.size();
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) >= duty) begin
                sample_valid = 1'b0;
                sample = DW'($urandom);
                step();
            end
            sample_valid = 1'b1;
            sample = DW'(stream[i]);
            step();
        end
        sample_valid = 1'b0;
        if (stop_at >= 0) begin
            $display("frame %0d %s partial writes=%0d", frame_no, name, wr_seen);
            return;
        end
        check("write_count", wr_seen, n);
        if (trig < 0) begin
            check("no_ready", frame_ready, 1'b0);
            check("still_busy", busy, 1'b1);
            $display("frame %0d %s no trigger writes=%0d", frame_no, name, wr_seen);
            return;
        end
        // Last write strobe is visible now; frame_ready must follow one cycle later.
        check("ready_lag", frame_ready, 1'b0);
        step();
        check("ready", frame_ready, 1'b1);
        check("start_addr", start_addr, (trig - PRE) % DEPTH);
        check("forced", forced, frc);
        // Samples arriving while the frame is held must not be written.
        for (int i = 0; i < 5; i++) begin
            sample_valid = 1'b1;
            sample = DW'($urandom);
            step();
            check("hold_ready", frame_ready, 1'b1);
        end
        sample_valid = 1'b0;
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        check("ack_drop", frame_ready, 1'b0);
        check("ack_busy", busy, cont);
        check("writes_after_ack", wr_seen, n);
        $display("frame %0d %s trig=%0d writes=%0d start=%0d forced=%0b",
                 frame_no, name, trig, wr_seen, start_addr, forced);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr_en"}, wr_en, 1'b0);
        check({tag, "_ready"}, frame_ready, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) step();
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_start", start_addr, 0);
        check("rst_forced", forced, 1'b0);
        check_idle_outputs("rst");
        reset = 1'b1;
        step();

        // Rising ramp reaches 128 on the first WAIT_TRIG sample: 640 writes, start 0.
        run_frame("rise_ramp", K_UP, 64, 128, 1'b1, 1'b0, 0, 100, 1'b0, 1'b1, 5000, -1);
        // Descending ramp crosses 129->128 at the same index, with 50% gaps.
        run_frame("fall_gaps", K_DOWN, 192, 128, 1'b0, 1'b0, 0, 50, 1'b0, 1'b1, 5000, -1);
        run_frame("auto_100", K_CONST, 10, 128, 1'b1, 1'b1, 100, 100, 1'b0, 1'b1, 5000, -1);
        run_frame("auto_0", K_CONST, 10, 128, 1'b1, 1'b1, 0, 100, 1'b0, 1'b1, 5000, -1);
        // No auto: the pointer wraps and frame_ready never rises. Abort out of it.
        run_frame("auto_off", K_CONST, 10, 128, 1'b1, 1'b0, 0, 100, 1'b0, 1'b1, 800, -1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle_outputs("abort_wait");
        // Long waits, including a trigger address below PRE.
        run_frame("wrap_2000", K_STEP, 2000, 128, 1'b1, 1'b0, 0, 100, 1'b0, 1'b1, 5000, -1);
        run_frame("wrap_low", K_STEP, 1950, 128, 1'b1, 1'b0, 0, 90, 1'b0, 1'b1, 5000, -1);
        // Continuous: the second frame starts without arm, then the block idles.
        run_frame("cont_a", K_UP, int'($urandom_range(255)), int'($urandom_range(1, 254)),
                  1'b1, 1'b0, 0, 80, 1'b1, 1'b1, 5000, -1);
        run_frame("cont_b", K_DOWN, int'($urandom_range(255)), int'($urandom_range(1, 254)),
                  1'b0, 1'b0, 0, 80, 1'b0, 1'b0, 5000, -1);

        // Abort in POST. It beats a simultaneous arm, and the sample is not written.
        run_frame("abort_post", K_UP, 0, 128, 1'b1, 1'b0, 0, 100, 1'b0, 1'b1, 5000, 150);
        abort = 1'b1;
        arm = 1'b1;
        sample_valid = 1'b1;
        sample = 8'd77;
        step();
        abort = 1'b0;
        arm = 1'b0;
        sample_valid = 1'b0;
        check_idle_outputs("abort_post");
        step();
        check("abort_stays_idle", busy, 1'b0);
        run_frame("after_abort", K_RAND, 0, int'($urandom_range(1, 254)), 1'b1, 1'b0, 0, 100,
                  1'b0, 1'b1, 5000, -1);

        // Asynchronous reset in WAIT_TRIG, checked before the next clock edge.
        run_frame("reset_wait", K_CONST, 10, 128, 1'b1, 1'b0, 0, 100, 1'b0, 1'b1, 200, PRE + 20);
        #2 reset = 1'b0;
        #1;
        check("areset_wr_addr", wr_addr, 0);
        check("areset_wr_data", wr_data, 0);
        check("areset_start", start_addr, 0);
        check("areset_forced", forced, 1'b0);
        check_idle_outputs("areset");
        step();
        reset = 1'b1;
        step();
        run_frame("after_reset", K_UP, 64, 128, 1'b1, 1'b0, 0, 100, 1'b0, 1'b1, 5000, -1);

        // Randomised frames: data, level, slope, auto mode, timeout and duty.
        for (int f = 0; f < 4; f++) begin
            run_frame("random", K_RAND, 0, int'($urandom_range(1, 254)), 1'($urandom_range(1)),
                      1'($urandom_range(1)), int'($urandom_range(300)),
                      int'($urandom_range(60, 100)), 1'b0, 1'b1, 5000, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
